seq_scan_ctrl: RTL and testbench

Controller that feeds parallel words into a programmable serial pattern matcher and schedules the scan. It accepts words over a valid/ready handshake and serializes each word MSB-first, one bit per clock. It counts pattern hits, with overlapping matches allowed, and raises done when a programmed hit threshold is reached. It is the programmable, stream-fed successor to the fixed "01010" serial detector and sits between a word-wide data source and the status/interrupt logic.

---
 rtl/seq_scan_ctrl_pkg.sv | 20 ++
 rtl/seq_scan_ctrl_if.sv | 11 +
 rtl/seq_scan_ctrl_matcher.sv | 45 ++++
 rtl/seq_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and sizing helpers for the serial scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_WORD_W  = 8;
  localparam int DEF_PAT_MAX = 8;
  localparam int DEF_CNT_W   = 16;

  // Pattern length must be able to hold PAT_MAX itself, not just PAT_MAX-1.
  function automatic int len_w(input int pat_max);
    return $clog2(pat_max) + 1;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-stream valid/ready handshake feeding the scan controller.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 8
) ();
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_scan_ctrl_matcher.sv
// Serial pattern matcher: bit history, saturating bits-seen count, masked compare.
// Assumes PAT_MAX >= 2.
module seq_pattern_matcher #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit,
  output logic               match
);

  logic [PAT_MAX-1:0] hist, hist_nxt, mask;
  logic [LEN_W-1:0]   seen, seen_nxt;

  // hit is the compare on the post-shift history; match is its registered copy.
  always_comb begin
    hist_nxt = {hist[PAT_MAX-2:0], bit_in};
    seen_nxt = (seen == LEN_W'(PAT_MAX)) ? seen : seen + 1'b1;
    mask     = '0;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len));
    hit = bit_valid && (len != '0) && (seen_nxt >= len) &&
          (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      hist  <= '0;
      seen  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (bit_valid) begin
        hist <= hist_nxt;
        seen <= seen_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Stream-fed scan controller: accepts words, shifts them MSB-first through the
// pattern matcher, counts hits and stops once the programmed threshold is met.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int  WORD_W  = DEF_WORD_W,
  parameter int  PAT_MAX = DEF_PAT_MAX,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = len_w(PAT_MAX)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  seq_scan_ctrl_if.slave     in_if,
  output logic               bit_valid,
  output logic               bit_out,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [BC_W-1:0]    bit_cnt;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   thresh_q, cnt_q, cnt_nxt;
  logic               hit, accept, go, last_bit, reached, cfg_legal, len_ok;

  assign in_if.in_ready = (state == S_WAIT);
  assign busy           = (state == S_WAIT) || (state == S_SHIFT);
  assign done           = (state == S_DONE);
  assign bit_valid      = (state == S_SHIFT);
  assign bit_out        = bit_valid & shreg[WORD_W-1];
  assign match_count    = cnt_q;

  assign accept    = in_if.in_valid && (state == S_WAIT);
  assign len_ok    = (len_q != '0);
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
  // A config write in DONE takes priority over a simultaneous start.
  assign go        = start && len_ok &&
                     ((state == S_IDLE) || ((state == S_DONE) && !cfg_we));
  assign last_bit  = bit_valid && (bit_cnt == BC_W'(WORD_W - 1));
  assign cnt_nxt   = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // Includes the hit from the bit shifting this cycle, so a threshold met on
  // the final bit of a word still lands in DONE.
  assign reached   = (thresh_q != '0) && (cnt_nxt >= thresh_q);

  seq_pattern_matcher #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (go),
    .bit_valid (bit_valid),
    .bit_in    (bit_out),
    .pattern   (pat_q),
    .len       (len_q),
    .hit       (hit),
    .match     (match)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go) state_nxt = S_WAIT;
      S_WAIT:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = reached ? S_DONE : S_WAIT;
      S_DONE: begin
        if (cfg_we)  state_nxt = S_IDLE;
        else if (go) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (cfg_we && (busy || !cfg_legal)) ||
               (start && (state == S_IDLE) && !len_ok);
      if (cfg_we && !busy && cfg_legal) begin
        pat_q    <= cfg_pattern;
        len_q    <= cfg_len;
        thresh_q <= cfg_thresh;
      end
      cnt_q <= go ? '0 : cnt_nxt;
      if (accept) begin
        shreg   <= in_if.in_data;
        bit_cnt <= '0;
      end else if (bit_valid) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed scenarios plus random scans against a
// bit-queue reference model. A second instance with CNT_W=2 covers saturation.
module tb_seq_scan_ctrl;

  localparam int M_IDLE = 0, M_WAIT = 1, M_DONE = 2;

  logic        clk = 1'b0, reset_n = 1'b0, cfg_we = 1'b0, start = 1'b0;
  logic        in_valid = 1'b0, b_en = 1'b0;
  logic [7:0]  cfg_pattern = '0, in_data = '0;
  logic [3:0]  cfg_len = '0;
  logic [15:0] cfg_thresh = '0;

  logic        in_ready, bit_valid, bit_out, match, busy, done, err;
  logic [15:0] match_count;
  logic        bit_valid_b, bit_out_b, match_b, busy_b, done_b, err_b;
  logic [1:0]  match_count_b;

  int nchk = 0, nerr = 0;

  // reference model state
  bit         q[$];
  logic [7:0] mpat = '0;
  int         mlen = 0, mthr = 0, mcnt = 0, mcnt_b = 0, mstate = M_IDLE;
  int         b_pulses = 0;

  seq_scan_ctrl_if #(.WORD_W(8)) ifa ();
  seq_scan_ctrl_if #(.WORD_W(8)) ifb ();
  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifb.in_valid = in_valid & b_en;
  assign ifb.in_data  = in_data;
  assign in_ready     = ifa.in_ready;

  seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .in_if(ifa.slave),
    .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
    .match_count(match_count), .busy(busy), .done(done), .err(err)
  );

  seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(2'b00), .start(start & b_en), .in_if(ifb.slave),
    .bit_valid(bit_valid_b), .bit_out(bit_out_b), .match(match_b),
    .match_count(match_count_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  // Hit when the last mlen scanned bits, newest first, equal pattern bits 0..mlen-1.
  function automatic bit model_hit();
    if (mlen == 0 || q.size() < mlen) return 1'b0;
    for (int j = 0; j < mlen; j++)
      if (q[q.size()-1-j] != mpat[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    mpat = '0; mlen = 0; mthr = 0; mcnt = 0; mcnt_b = 0; mstate = M_IDLE;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input int len, input int thr);
    bit exp_err;
    exp_err = (mstate == M_WAIT) || len < 1 || len > 8;
    if (!exp_err) begin mpat = pat; mlen = len; mthr = thr; end
    if (mstate == M_DONE) mstate = M_IDLE;
    cfg_pattern = pat; cfg_len = 4'(len); cfg_thresh = 16'(thr); cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    nchk++;
    if (err !== exp_err) begin
      nerr++; $display("FAIL cfg_err len=%0d: got %b expected %b", len, err, exp_err);
    end
    nchk++;
    if (done !== (mstate == M_DONE)) begin
      nerr++; $display("FAIL cfg_done: got %b expected %b", done, mstate == M_DONE);
    end
  endtask

  task automatic do_start();
    bit exp_err;
    exp_err = (mstate == M_IDLE) && (mlen == 0);
    if (mstate != M_WAIT && mlen != 0) begin
      q.delete(); mcnt = 0; mcnt_b = 0; mstate = M_WAIT;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nchk++;
    if (err !== exp_err || busy !== (mstate == M_WAIT) || match_count !== 16'(mcnt)) begin
      nerr++;
      $display("FAIL start: err/busy/count got %b/%b/%0d expected %b/%b/%0d",
               err, busy, match_count, exp_err, mstate == M_WAIT, mcnt);
    end
  endtask

  // Offers one word; if accepted, checks every shift cycle and the cycle after.
  task automatic scan_word(input logic [7:0] w, input bit cfg_mid);
    bit acc, b, h, ph;
    acc = (mstate == M_WAIT);
    nchk++;
    if (in_ready !== acc) begin
      nerr++; $display("FAIL in_ready: got %b expected %b", in_ready, acc);
    end
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    if (!acc) begin
      repeat (3) begin
        nchk++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || done !== (mstate == M_DONE)) begin
          nerr++;
          $display("FAIL no_accept: bit_valid/busy/done got %b/%b/%b expected 0/0/%b",
                   bit_valid, busy, done, mstate == M_DONE);
        end
        @(negedge clk);
      end
      return;
    end
    ph = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = w[7-i];
      nchk++;
      if (bit_valid !== 1'b1 || bit_out !== b) begin
        nerr++;
        $display("FAIL shift bit %0d: valid/bit got %b/%b expected 1/%b", i, bit_valid, bit_out, b);
      end
      nchk++;
      if (match !== ph || match_count !== 16'(mcnt)) begin
        nerr++;
        $display("FAIL match bit %0d: match/count got %b/%0d expected %b/%0d",
                 i, match, match_count, ph, mcnt);
      end
      nchk++;
      if (err !== (cfg_mid && i == 3)) begin
        nerr++; $display("FAIL shift_err bit %0d: got %b expected %b", i, err, cfg_mid && i == 3);
      end
      if (b_en) begin
        b_pulses += int'(match_b);
        nchk++;
        if (match_b !== ph || match_count_b !== 2'(mcnt_b)) begin
          nerr++;
          $display("FAIL sat bit %0d: match/count got %b/%0d expected %b/%0d",
                   i, match_b, match_count_b, ph, mcnt_b);
        end
      end
      if (cfg_mid && i == 2) begin
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd3; cfg_thresh = 16'd1;
      end
      q.push_back(b);
      if (q.size() > 16) void'(q.pop_front());
      h = model_hit();
      if (h) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt_b < 3) mcnt_b++;
      end
      ph = h;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    if (mthr != 0 && mcnt >= mthr) mstate = M_DONE;
    nchk++;
    if (match !== ph || match_count !== 16'(mcnt) || bit_valid !== 1'b0) begin
      nerr++;
      $display("FAIL word_end: match/count/valid got %b/%0d/%b expected %b/%0d/0",
               match, match_count, bit_valid, ph, mcnt);
    end
    nchk++;
    if (done !== (mstate == M_DONE) || in_ready !== (mstate == M_WAIT)) begin
      nerr++;
      $display("FAIL word_state: done/in_ready got %b/%b expected %b/%b",
               done, in_ready, mstate == M_DONE, mstate == M_WAIT);
    end
    if (b_en) begin
      b_pulses += int'(match_b);
      nchk++;
      if (match_b !== ph || match_count_b !== 2'(mcnt_b)) begin
        nerr++;
        $display("FAIL sat_end: match/count got %b/%0d expected %b/%0d",
                 match_b, match_count_b, ph, mcnt_b);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nchk++;
    if ({bit_valid, bit_out, match, busy, done, err, in_ready} !== 7'b0 || match_count !== 16'd0) begin
      nerr++; $display("FAIL reset_hold: outputs not zero, count=%0d", match_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    nchk++;
    if ({bit_valid, bit_out, match, busy, done, err, in_ready} !== 7'b0) begin
      nerr++; $display("FAIL reset_release: outputs not zero");
    end
    do_start();
  endtask

  task automatic test_cfg_illegal();
    do_cfg(8'h0A, 5, 0);
    do_cfg(8'hFF, 0, 3);
    do_cfg(8'hFF, 9, 3);
  endtask

  task automatic test_basic();
    do_start();
    scan_word(8'h2A, 1'b0);
    nchk++;
    if (match_count !== 16'd2 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL basic: count/in_ready got %0d/%b expected 2/1", match_count, in_ready);
    end
  endtask

  task automatic test_cfg_busy();
    do_cfg(8'h1F, 3, 1);
    scan_word(8'h2A, 1'b1);
    nchk++;
    if (match_count !== 16'd4) begin
      nerr++; $display("FAIL cfg_busy: count got %0d expected 4", match_count);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 8'h2A;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    nchk++;
    if ({bit_valid, bit_out, match, busy, done, err, in_ready} !== 7'b0 || match_count !== 16'd0) begin
      nerr++; $display("FAIL reset_mid: outputs not zero, count=%0d", match_count);
    end
    reset_n = 1'b1;
    q.delete();
    mpat = '0; mlen = 0; mthr = 0; mcnt = 0; mcnt_b = 0; mstate = M_IDLE;
    do_cfg(8'h0A, 5, 0);
    do_start();
    scan_word(8'h55, 1'b0);
    nchk++;
    if (match_count !== 16'd2) begin
      nerr++; $display("FAIL reset_mid_rescan: count got %0d expected 2", match_count);
    end
  endtask

  task automatic test_thresh();
    apply_reset();
    do_cfg(8'h0A, 5, 2);
    do_start();
    scan_word(8'h2A, 1'b0);
    nchk++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || match_count !== 16'd2) begin
      nerr++;
      $display("FAIL thresh: done/busy/in_ready/count got %b/%b/%b/%0d expected 1/0/0/2",
               done, busy, in_ready, match_count);
    end
    scan_word(8'h2A, 1'b0);
    nchk++;
    if (match_count !== 16'd2) begin
      nerr++; $display("FAIL thresh_hold: count got %0d expected 2", match_count);
    end
  endtask

  task automatic test_cross_word();
    do_cfg(8'h09, 4, 0);
    do_start();
    scan_word(8'h01, 1'b0);
    scan_word(8'h20, 1'b0);
    nchk++;
    if (match_count !== 16'd1) begin
      nerr++; $display("FAIL cross_word: count got %0d expected 1", match_count);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      if (mstate == M_WAIT && $urandom_range(0, 1) == 1) apply_reset();
      do_cfg(8'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
      do_start();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        if ($urandom_range(0, 1) == 1) scan_word(8'($urandom), 1'b0);
        else scan_word(8'($urandom) & 8'hA5, 1'b0);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    b_en = 1'b1;
    b_pulses = 0;
    do_cfg(8'h01, 1, 0);
    do_start();
    scan_word(8'hFF, 1'b0);
    nchk++;
    if (match_count_b !== 2'd3 || b_pulses != 8 || match_count !== 16'd8) begin
      nerr++;
      $display("FAIL saturation: count_b/pulses/count got %0d/%0d/%0d expected 3/8/8",
               match_count_b, b_pulses, match_count);
    end
    b_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_illegal();
    test_basic();
    test_cfg_busy();
    test_reset_mid();
    test_thresh();
    test_cross_word();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
